// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Size encodings, FSM states and byte-lane mask helpers.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_e;

  function automatic logic [63:0] size_mask(
    input logic [1:0] size,
    input logic [2:0] off
  );
    logic [7:0]  be;
    logic [63:0] m;
    unique case (size)
      SIZE_B:  be = 8'h01;
      SIZE_H:  be = 8'h03;
      SIZE_W:  be = 8'h0f;
      default: be = 8'hff;
    endcase
    be = be << off;
    for (int i = 0; i < 8; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [2:0] off
  );
    unique case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return |off[1:0];
      default: return |off;
    endcase
  endfunction

  function automatic logic [2:0] align_off(
    input logic [1:0] size,
    input logic [2:0] off
  );
    unique case (size)
      SIZE_B:  return off;
      SIZE_H:  return {off[2:1], 1'b0};
      SIZE_W:  return {off[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane extraction for loads and merge for partial stores.
// Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [63:0] line,
  input  logic [63:0] wdata,
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] load_data,
  output logic [63:0] store_data
);

  logic [63:0] lane;
  logic [63:0] mask;
  logic        sgn;

  always_comb begin
    lane      = line >> {off, 3'b000};
    mask      = size_mask(size, off);
    sgn       = 1'b0;
    load_data = lane;
    unique case (size)
      SIZE_B: begin
        sgn       = lane[7] & ~is_unsigned;
        load_data = {{56{sgn}}, lane[7:0]};
      end
      SIZE_H: begin
        sgn       = lane[15] & ~is_unsigned;
        load_data = {{48{sgn}}, lane[15:0]};
      end
      SIZE_W: begin
        sgn       = lane[31] & ~is_unsigned;
        load_data = {{32{sgn}}, lane[31:0]};
      end
      default: load_data = lane;
    endcase
    store_data = (line & ~mask)
               | ((wdata << {off, 3'b000}) & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store master for data_memory: handshake, FSM,
// read-modify-write for partial stores, error on misalignment.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [63:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [63:0]           mem_write_data,
  input  logic [63:0]           mem_read_data
);

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [2:0]            off_q, off_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [63:0]           line_q, line_d;
  logic                  rvalid_q, rvalid_d;
  logic [63:0]           rdata_q, rdata_d;
  logic                  rerr_q, rerr_d;
  logic                  mrd_q, mrd_d;
  logic                  mwr_q, mwr_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [63:0]           mwdata_q, mwdata_d;

  logic [2:0]  in_off;
  logic        in_mis;
  logic [63:0] line_src;
  logic [63:0] load_data;
  logic [63:0] store_data;

  assign in_off = req_addr[2:0];
  assign in_mis = CHECK_ALIGN ? misaligned(req_size, in_off)
                              : 1'b0;

  // Memory data is only valid while READ is driving mem_read.
  assign line_src = (state_q == S_READ) ? mem_read_data : line_q;

  lsu_lane_align u_align (
    .line        (line_src),
    .wdata       (wdata_q),
    .off         (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    line_d   = line_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    mrd_d    = mrd_q;
    mwr_d    = mwr_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          off_d   = CHECK_ALIGN ? in_off
                                : align_off(req_size, in_off);
          wdata_d = req_wdata;
          maddr_d = {req_addr[ADDR_WIDTH-1:3], 3'b000};
          if (in_mis) begin
            state_d  = S_RESP;
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
            rdata_d  = '0;
          end else if (req_write && req_size == SIZE_D) begin
            state_d  = S_WRITE;
            mwr_d    = 1'b1;
            mwdata_d = req_wdata;
          end else begin
            state_d = S_READ;
            mrd_d   = 1'b1;
          end
        end
      end
      S_READ: begin
        line_d = mem_read_data;
        mrd_d  = 1'b0;
        if (wr_q) begin
          state_d  = S_WRITE;
          mwr_d    = 1'b1;
          mwdata_d = store_data;
        end else begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          rerr_d   = 1'b0;
          rdata_d  = load_data;
        end
      end
      S_WRITE: begin
        mwr_d    = 1'b0;
        state_d  = S_RESP;
        rvalid_d = 1'b1;
        rerr_d   = 1'b0;
        rdata_d  = '0;
      end
      default: begin
        if (resp_ready) begin
          state_d  = S_IDLE;
          rvalid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      size_q   <= SIZE_B;
      uns_q    <= 1'b0;
      off_q    <= '0;
      wdata_q  <= '0;
      line_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      line_q   <= line_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign resp_valid     = rvalid_q;
  assign resp_rdata     = rdata_q;
  assign resp_error     = rerr_q;
  assign mem_read       = mrd_q;
  // A write pending on a reset edge must not commit.
  assign mem_write      = mwr_q & ~reset;
  assign mem_address    = maddr_q;
  assign mem_write_data = mwdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side master for data_memory; sits between the execute stage and data_memory.
- Accepts byte, half, word and doubleword load/store requests over a valid/ready handshake. Issues mem_read/mem_write cycles to data_memory.
- Sub-doubleword stores are done as read-modify-write. Load data is returned little-endian, sign- or zero-extended.
- Misaligned requests get an error response and cause no memory access.

Parameters:
- ADDR_WIDTH, 64, width of req_addr and mem_address.
- CHECK_ALIGN, 1, when 1 misaligned requests raise resp_error; when 0 the low address bits are forced to natural alignment.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 doubleword
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  64  store data, right-aligned
- resp_valid  out  1  response available
- resp_ready  in  1  response consumed when resp_valid && resp_ready
- resp_rdata  out  64  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned request
- mem_read  out  1  to data_memory.mem_read
- mem_write  out  1  to data_memory.mem_write
- mem_address  out  ADDR_WIDTH  doubleword address, req_addr with bits [2:0] cleared
- mem_write_data  out  64  to data_memory.write_data
- mem_read_data  in  64  from data_memory.read_data, combinational within the cycle

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- req_ready = (state == IDLE).
- On acceptance, the request is registered.
- Alignment check uses off = addr[2:0]:
  - half: off[0] must be 0
  - word: off[1:0] must be 0
  - dword: off must be 0
  - byte: never misaligned
- Transitions out of IDLE:
  - misaligned (CHECK_ALIGN=1) -> RESP with resp_error=1
  - load -> READ
  - dword store -> WRITE
  - sub-dword store -> READ
- READ:
  - drive mem_read=1 and mem_address; capture mem_read_data into the line register at the cycle end.
  - Next state: RESP for a load, WRITE for a store.
- Load extraction: lane = line >> (off*8), truncated to the size, then sign- or zero-extended to 64 bits. Doubleword loads ignore req_unsigned.
- WRITE:
  - mem_write=1 for exactly one cycle.
  - mem_write_data = (line & ~mask) | ((wdata << off*8) & mask), where mask covers the size bytes at off. For a dword store, mem_write_data = wdata.
  - Next state: RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_error held stable until resp_ready.
  - resp_valid && resp_ready -> IDLE. The next request can be accepted the cycle after.
- mem_read and mem_write are never both high. Both are 0 outside READ/WRITE.
- Latency (acceptance edge to first resp_valid cycle):
  - load: 2 cycles
  - dword store: 2 cycles
  - sub-dword store: 3 cycles
  - error: 1 cycle
- Reset values:
  - state = IDLE
  - req_ready = 1 (follows from IDLE, not an independent register)
  - resp_valid = 0, resp_rdata = 0, resp_error = 0
  - mem_read = 0, mem_write = 0, mem_address = 0, mem_write_data = 0
  - line register = 0
- Reset mid-operation:
  - mem_write is gated with !reset, so no memory write commits on a reset edge.
  - Any in-flight request and any pending response are discarded.
- A request presented while the unit is not IDLE is not accepted. The requester holds it until req_ready.

Decomposition:
- Package lsu_pkg: size encodings (SIZE_B/H/W/D), the state enum, and a function for size-to-byte-mask.
- Sub-module lsu_lane_align, combinational:
  - inputs: line, wdata, off, size, unsigned
  - outputs: load_data, merged store word
- load_store_unit keeps the FSM, request registers and the data_memory interface.

Test Plan:
- Dword store then load: store addr 0x10, data 64'hAAAA_BBBB_CCCC_DDDD. Load dword from 0x10 -> resp_rdata = 64'hAAAA_BBBB_CCCC_DDDD, latency 2 each, exactly one mem_write pulse.
- Byte store RMW: line at 0x20 = 64'h1122_3344_5566_7788. Store byte 0xEF at 0x23 -> line = 64'h1122_3344_EF66_7788. Sequence is READ then WRITE, latency 3.
- Extension:
  - line = 64'h0000_0000_8000_00F0
  - signed byte load at 0x0 -> 64'hFFFF_FFFF_FFFF_FFF0
  - unsigned byte load -> 64'h0000_0000_0000_00F0
  - signed word load at 0x0 -> 64'hFFFF_FFFF_8000_00F0
- Misaligned: word load at 0x22 -> resp_error=1, resp_rdata=0, no mem_read/mem_write, latency 1.
- Backpressure: hold resp_ready=0 for 5 cycles during a load. resp_valid and resp_rdata are stable, req_ready=0, and a new req_valid is not accepted until 1 cycle after resp_ready.
- Reset: assert reset during WRITE of a half store. No memory change, and all outputs read back at their reset values next cycle.
